// File: rtl/control_ram_pkg.sv
// -----------------------------------------------------------------------------
// control_ram_pkg
//   Shared types and default constants for the control_ram block.
//   - state_t : controller state (CLEAR = post-reset zeroing sweep, IDLE = normal)
//   - DEFAULT_* : default geometry used by control_ram and its storage array
//   - depth_words() : helper returning the number of implemented words
// -----------------------------------------------------------------------------
package control_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 8;

  function automatic int depth_words(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/control_ram_array.sv
// -----------------------------------------------------------------------------
// control_ram_array
//   Single-port synchronous storage of 2**DEPTH_LOG2 words, write-first read.
//   Ports:
//     clk   - clock, rising edge
//     we    - write enable; writes wdata to mem[idx] at the edge
//     idx   - word index for both read and write
//     wdata - write data
//     rdata - registered read data; on a write it returns the new wdata
//   No reset: contents are defined only once the owner has written them.
// -----------------------------------------------------------------------------
module control_ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
      rdata    <= wdata;  // write-first: the port sees the value just written
    end else begin
      rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/control_ram.sv
// -----------------------------------------------------------------------------
// control_ram
//   Word-addressed RAM that zeroes itself after every reset. Following reset
//   the controller sits in CLEAR and writes zero to one word per cycle, from
//   address 0 upwards; after the last word it moves to IDLE where normal
//   read/write traffic is served.
//
//   Ports:
//     clk         - sole clock, rising edge
//     reset       - synchronous, active-high; restarts the clear sweep
//     addr        - word address for read and write (ADDR_WIDTH bits)
//     dataIn      - write data
//     writeEnable - 1 = write dataIn to addr this cycle (IDLE, in range only)
//     dataOut     - read data for the addr sampled at the previous edge;
//                   zero for out-of-range reads and throughout CLEAR/reset
//     busy        - 1 exactly while in CLEAR
//     addrError   - 1 when the previous cycle's addr was out of range (IDLE)
//     dbg_state   - current controller state, for observation only
//
//   There is no handshake: every cycle in IDLE is a read of addr and, when
//   writeEnable is set, a write to it. Traffic during CLEAR is dropped.
// -----------------------------------------------------------------------------
module control_ram
  import control_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  busy,
  output logic                  addrError,
  output state_t                dbg_state
);

  // One extra counter bit so the sweep index can never wrap back to 0.
  localparam int                CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(depth_words(DEPTH_LOG2) - 1);

  state_t                state;
  logic [CNT_W-1:0]      sweep_idx;
  logic                  rd_valid;   // last edge performed a legal IDLE read
  logic                  addr_err_q;
  logic                  in_range;

  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Any set bit above the implemented depth is out of range; high bits never
  // alias onto low words.
  generate
    if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_range
      assign in_range = (addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // Storage port steering: the sweep owns the port in CLEAR, the user in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_idx   = addr[DEPTH_LOG2-1:0];
    arr_wdata = dataIn;
    if (state == CLEAR) begin
      arr_idx   = sweep_idx[DEPTH_LOG2-1:0];
      arr_wdata = '0;
      arr_we    = !reset;
    end else begin
      arr_we    = !reset && writeEnable && in_range;
    end
  end

  control_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Controller: state, sweep counter and the output qualifiers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_idx  <= '0;
      rd_valid   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rd_valid   <= 1'b0;
          addr_err_q <= 1'b0;
          sweep_idx  <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          rd_valid   <= in_range;
          addr_err_q <= !in_range;
        end
        default: begin
          state      <= CLEAR;
          sweep_idx  <= '0;
          rd_valid   <= 1'b0;
          addr_err_q <= 1'b0;
        end
      endcase
    end
  end

  // The array's registered read is gated by a flag registered on the same
  // edge, so out-of-range reads and sweep/reset cycles present zero.
  assign dataOut   = rd_valid ? arr_rdata : '0;
  assign addrError = addr_err_q;
  assign busy      = (state == CLEAR);
  assign dbg_state = state;

endmodule

// File: tb/tb_control_ram.sv
// -----------------------------------------------------------------------------
// tb_control_ram
//   Directed scenarios followed by random traffic, all compared every cycle
//   against a word-array reference model of the RAM's visible behaviour.
// -----------------------------------------------------------------------------
module tb_control_ram;
  import control_ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int DL    = 8;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dataIn = '0;
  logic          writeEnable = 1'b0;
  logic [DW-1:0] dataOut;
  logic          busy;
  logic          addrError;
  state_t        dbg_state;

  always #5 clk = ~clk;

  control_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .dataOut     (dataOut),
    .busy        (busy),
    .addrError   (addrError),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  // Memory as a plain array; "clear_left" is how many words of the zeroing
  // sweep are still to go (0 = normal operation).
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = 0;
  int            clear_pos  = 0;
  logic [DW-1:0] exp_q [$];
  logic          exp_err;
  logic          exp_busy;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic w);
    if (rst) begin
      clear_left = DEPTH;
      clear_pos  = 0;
      exp_q.push_back('0);
      exp_err  = 1'b0;
      exp_busy = 1'b1;
    end else if (clear_left > 0) begin
      ref_mem[clear_pos] = '0;
      clear_pos++;
      clear_left--;
      exp_q.push_back('0);
      exp_err  = 1'b0;
      exp_busy = (clear_left > 0);
    end else begin
      exp_busy = 1'b0;
      if (a < DEPTH) begin
        if (w) ref_mem[a] = d;
        exp_q.push_back(ref_mem[a]);
        exp_err = 1'b0;
      end else begin
        exp_q.push_back('0);
        exp_err = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic w);
    reset       = rst;
    addr        = a;
    dataIn      = d;
    writeEnable = w;
    @(posedge clk);
    model_edge(rst, a, d, w);
    #1;
    check("dataOut", 32'(dataOut), 32'(exp_q.pop_front()));
    check("addrError", 32'(addrError), 32'(exp_err));
    check("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Reset for n cycles, then run until busy drops; returns sweep length.
  // Writes to addr 0 are attempted throughout and must be dropped.
  task automatic reset_and_sweep(input int n, output int sweep_len);
    sweep_len = 0;
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 8'h5A, 1'b1);
    while (busy === 1'b1 && sweep_len < 1000) begin
      step(1'b0, 32'h0, 8'h5A, 1'b1);
      sweep_len++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            len;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    logic          rst;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_err  = 1'b0;
    exp_busy = 1'b1;

    // Reset 5 cycles, sweep must last exactly DEPTH cycles; writes during
    // reset/sweep are ignored so addr 0 reads back zero.
    reset_and_sweep(5, len);
    check("sweep_len", 32'(len), 32'(DEPTH));
    step(1'b0, 32'h0, 8'h00, 1'b0);
    check("addr0_after_sweep", 32'(dataOut), 32'h00);

    // Write then read addr 0.
    step(1'b0, 32'h0, 8'h5A, 1'b1);
    step(1'b0, 32'h0, 8'h00, 1'b0);
    check("rd_addr0", 32'(dataOut), 32'h5A);

    // Same-cycle write/read at 0x10 returns the new data.
    step(1'b0, 32'h10, 8'h3C, 1'b1);
    check("write_first", 32'(dataOut), 32'h3C);

    // Out-of-range write, then reads of 0x00 and 0x100.
    step(1'b0, 32'h100, 8'hFF, 1'b1);
    check("oor_err", 32'(addrError), 32'h1);
    step(1'b0, 32'h0, 8'h00, 1'b0);
    check("oor_err_drop", 32'(addrError), 32'h0);
    check("addr0_kept", 32'(dataOut), 32'h5A);
    step(1'b0, 32'h100, 8'h00, 1'b0);
    check("oor_rd_zero", 32'(dataOut), 32'h00);
    step(1'b0, 32'h8000_0000, 8'h11, 1'b1);  // high bit must not alias addr 0
    step(1'b0, 32'h0, 8'h00, 1'b0);
    check("no_alias", 32'(dataOut), 32'h5A);

    // Mid-operation reset wipes addr 5.
    step(1'b0, 32'h5, 8'hA5, 1'b1);
    step(1'b0, 32'h5, 8'h00, 1'b0);
    check("addr5_written", 32'(dataOut), 32'hA5);
    reset_and_sweep(2, len);
    check("sweep_len2", 32'(len), 32'(DEPTH));
    step(1'b0, 32'h5, 8'h00, 1'b0);
    check("addr5_cleared", 32'(dataOut), 32'h00);

    // Reset in mid-sweep restarts it from the beginning.
    step(1'b1, 32'h0, 8'h00, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 32'h0, 8'h00, 1'b0);
    reset_and_sweep(1, len);
    check("sweep_restart", 32'(len), 32'(DEPTH));

    // Random traffic, biased towards a small window so reads hit writes.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      case ($urandom_range(0, 9))
        0:       a = 32'h100 + 32'($urandom_range(0, 4095));
        1:       a = $urandom | 32'h0001_0000;
        2, 3:    a = 32'($urandom_range(0, DEPTH - 1));
        default: a = 32'($urandom_range(0, 7));
      endcase
      d = 8'($urandom_range(0, 255));
      w = ($urandom_range(0, 1) == 1);
      step(rst, a, d, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound in case anything stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
